control_unit: RTL and testbench
===============================

# control_unit

Hardwired sequencer for the 8-bit ALUSystem datapath.
- Fetches 16-bit instructions from Memory at PC into IR, one byte per cycle, high byte first.
- Decodes IR and drives every datapath select, function and enable line, one micro-step per Clock.
- Sits directly upstream of ALUSystem: consumes its IR contents and ALU flags, produces all of its control inputs.

## Interface
Parameters:
- CLEAR_ON_RESET, 1: when 1, the first cycle after Reset clears R1–R4, PC, AR and SP.

Ports (RegSel lines are active-low per bit; Mem_CS is active-low):
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IR_Out  in  16  instruction register contents.
- ALU_Flags  in  4  {O,N,C,Z}; bit0 = Z.
- RF_OutASel, RF_OutBSel  out  2 each  RF read selects.
- RF_FunSel  out  2  0 dec, 1 inc, 2 load, 3 clear.
- RF_RegSel  out  4  bit i enables Ri+1.
- ALU_FunSel  out  4  ALU operation.
- ARF_OutCSel, ARF_OutDSel  out  2 each  0/1 PC, 2 AR, 3 SP.
- ARF_FunSel  out  2  same encoding as RF_FunSel.
- ARF_RegSel  out  3  bit0 PC, bit1 AR, bit2 SP.
- IR_LH  out  1  0 loads IR[15:8], 1 loads IR[7:0].
- IR_Enable  out  1  active-high IR write.
- IR_Funsel  out  2  IR function.
- Mem_WR  out  1  1 write, 0 read.
- Mem_CS  out  1  memory chip select.
- MuxASel, MuxBSel  out  2 each  datapath mux selects.
- MuxCSel  out  1  datapath mux select.
- Halted  out  1  high in HALT.
- State  out  3  current state, for debug.

## Operation
- Instruction format: IR[15:12] opcode, IR[11:10] Rd, IR[9:8] Rs, IR[7:0] imm/addr.
- Opcodes:
  - 0 LD: Rd←M[addr].
  - 1 ST: M[addr]←Rd.
  - 2 MOVI: Rd←imm.
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: Rd←Rd op Rs. ALU codes 0100, 0110, 0111, 1000, 1001.
  - 8 NOT: Rd←~Rd. 9 LSL (1010), A LSR (1011).
  - B INC, C DEC: Rd via RF_FunSel 1/0.
  - D BRA: PC←imm. E BZ: PC←imm if Z=1. F HLT.
- Default (idle) outputs, also the value of every output during Reset:
  - RF_RegSel=1111, ARF_RegSel=111.
  - IR_Enable=0, Mem_CS=1, Mem_WR=0.
  - All selects and FunSels 0, Halted=0.
- States: CLEAR, FETCH_H, FETCH_L, EXEC1, EXEC2, HALT.
- Reset goes to CLEAR if CLEAR_ON_RESET=1, else FETCH_H.
- CLEAR: RF_RegSel=0000, ARF_RegSel=000, both FunSels=3 → FETCH_H.
- FETCH_H: fetch high byte.
  - ARF_OutDSel=0, Mem_CS=0, Mem_WR=0.
  - IR_Enable=1, IR_LH=0, IR_Funsel=2.
  - ARF_RegSel=110 with ARF_FunSel=1 (PC++).
  - → FETCH_L.
- FETCH_L: same as FETCH_H with IR_LH=1 → EXEC1.
- EXEC1:
  - LD/ST: AR←imm (MuxBSel=01, ARF_FunSel=2, ARF_RegSel=101) → EXEC2.
  - MOVI: MuxASel=00, RF_FunSel=2, Rd enabled → FETCH_H.
  - ALU ops: RF_OutASel=Rd, RF_OutBSel=Rs, MuxCSel=1, MuxASel=11, RF_FunSel=2, Rd enabled → FETCH_H.
  - INC/DEC: Rd enabled with FunSel 1/0 → FETCH_H.
  - BRA, and BZ with Z=1: PC load from imm → FETCH_H. BZ with Z=0: idle outputs → FETCH_H.
  - HLT: → HALT.
- EXEC2:
  - LD: ARF_OutDSel=2, Mem_CS=0, MuxASel=01, RF_FunSel=2, Rd enabled.
  - ST: ARF_OutDSel=2, RF_OutASel=Rd, MuxCSel=1, ALU_FunSel=0000, Mem_CS=0, Mem_WR=1.
  - Both → FETCH_H.
- HALT: idle outputs, Halted=1. Left only via Reset.
- Rd decode: one-hot active-low; Rd=0→1110, Rd=3→0111.

## Timing
- State register updates on posedge Clock.
- Outputs are combinational from State, IR_Out and ALU_Flags. The datapath commits each step on the edge ending that cycle.
- Latency: LD/ST take 4 cycles; every other instruction takes 3. HLT reaches HALT 3 cycles after its fetch begins.
- PC advances by 2 per fetch, wrapping 8'hFF→8'h00.
- BZ samples Z combinationally during EXEC1. Z reflects the last ALU result.
- Reset asserted in any state, including mid-instruction: outputs go to idle in that cycle. The next state is CLEAR or FETCH_H, and no partial writes occur.
- Opcode decode uses IR_Out only in EXEC1/EXEC2.

## Structure
- Package cu_pkg holds opcode constants, state encodings, FunSel constants (DEC/INC/LOAD/CLR) and ALU op codes.
- Sub-module cu_decode: combinational map from (state, IR_Out, Z) to control bundle. control_unit holds only the state register and next-state logic.

## Test plan
- Reset, CLEAR_ON_RESET=1: cycle 0 is CLEAR with all RegSel=0 and FunSel=3; cycle 1 is FETCH_H with ARF_OutDSel=0 and IR_LH=0.
- IR=16'h2A3C (MOVI R3,0x3C): in EXEC1, MuxASel=00, RF_FunSel=2, RF_RegSel=1011, then back to FETCH_H.
- IR=16'h3100 (ADD R1,R2): EXEC1 drives RF_OutASel=0, RF_OutBSel=1, ALU_FunSel=0100, RF_RegSel=1110.
- IR=16'h1440 (ST R2,0x40): EXEC1 loads AR from imm; EXEC2 drives Mem_WR=1, Mem_CS=0, ARF_OutDSel=2, RF_OutASel=1; 4 cycles total.
- IR=16'hE010 (BZ) with Z=0 vs Z=1: no PC write vs ARF_RegSel=110 with FunSel=2.
- IR=16'hF000: Halted=1 held for 20 cycles; Reset asserted in EXEC2 of a LD gives idle outputs, then CLEAR.

Source files
------------

// File: rtl/cu_pkg.sv
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared opcodes, state encoding, FunSel/ALU codes and the control
//            bundle used by the ALUSystem control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_FETCH_H = 3'd1,
    ST_FETCH_L = 3'd2,
    ST_EXEC1   = 3'd3,
    ST_EXEC2   = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] c_OP_LD   = 4'h0;
  localparam logic [3:0] c_OP_ST   = 4'h1;
  localparam logic [3:0] c_OP_MOVI = 4'h2;
  localparam logic [3:0] c_OP_ADD  = 4'h3;
  localparam logic [3:0] c_OP_SUB  = 4'h4;
  localparam logic [3:0] c_OP_AND  = 4'h5;
  localparam logic [3:0] c_OP_OR   = 4'h6;
  localparam logic [3:0] c_OP_XOR  = 4'h7;
  localparam logic [3:0] c_OP_NOT  = 4'h8;
  localparam logic [3:0] c_OP_LSL  = 4'h9;
  localparam logic [3:0] c_OP_LSR  = 4'hA;
  localparam logic [3:0] c_OP_INC  = 4'hB;
  localparam logic [3:0] c_OP_DEC  = 4'hC;
  localparam logic [3:0] c_OP_BRA  = 4'hD;
  localparam logic [3:0] c_OP_BZ   = 4'hE;
  localparam logic [3:0] c_OP_HLT  = 4'hF;

  localparam logic [1:0] c_FUN_DEC  = 2'd0;
  localparam logic [1:0] c_FUN_INC  = 2'd1;
  localparam logic [1:0] c_FUN_LOAD = 2'd2;
  localparam logic [1:0] c_FUN_CLR  = 2'd3;

  localparam logic [3:0] c_ALU_PASS = 4'b0000;
  localparam logic [3:0] c_ALU_NOT  = 4'b0010;
  localparam logic [3:0] c_ALU_ADD  = 4'b0100;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_AND  = 4'b0111;
  localparam logic [3:0] c_ALU_OR   = 4'b1000;
  localparam logic [3:0] c_ALU_XOR  = 4'b1001;
  localparam logic [3:0] c_ALU_LSL  = 4'b1010;
  localparam logic [3:0] c_ALU_LSR  = 4'b1011;

  localparam logic [1:0] c_MUXA_IMM = 2'b00;
  localparam logic [1:0] c_MUXA_MEM = 2'b01;
  localparam logic [1:0] c_MUXA_ALU = 2'b11;
  localparam logic [1:0] c_MUXB_IMM = 2'b01;

  localparam logic [1:0] c_ARF_PC = 2'd0;
  localparam logic [1:0] c_ARF_AR = 2'd2;

  // ARF write enables are active-low: bit0 PC, bit1 AR, bit2 SP
  localparam logic [2:0] c_ARF_EN_NONE = 3'b111;
  localparam logic [2:0] c_ARF_EN_PC   = 3'b110;
  localparam logic [2:0] c_ARF_EN_AR   = 3'b101;
  localparam logic [2:0] c_ARF_EN_ALL  = 3'b000;

  typedef struct packed {
    logic [1:0] rf_outa_sel;
    logic [1:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.rf_reg_sel  = 4'b1111;
    c.arf_reg_sel = c_ARF_EN_NONE;
    c.mem_cs      = 1'b1;
    return c;
  endfunction

  // One-hot active-low register enable for Rd (Rd=0 -> R1 -> 4'b1110)
  function automatic logic [3:0] rd_sel(input logic [1:0] rd);
    return ~(4'b0001 << rd);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      c_OP_ADD: code = c_ALU_ADD;
      c_OP_SUB: code = c_ALU_SUB;
      c_OP_AND: code = c_ALU_AND;
      c_OP_OR:  code = c_ALU_OR;
      c_OP_XOR: code = c_ALU_XOR;
      c_OP_NOT: code = c_ALU_NOT;
      c_OP_LSL: code = c_ALU_LSL;
      c_OP_LSR: code = c_ALU_LSR;
      default:  code = c_ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// Module   : cu_decode
// Purpose  : Combinational map from (state, instruction, Z) to the full
//            datapath control bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decode
  import cu_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_reset,
  input  logic [7:0] i_ir_hi,
  input  logic       i_z,
  output ctrl_t      o_ctrl
);

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;

  assign w_op = i_ir_hi[7:4];
  assign w_rd = i_ir_hi[3:2];
  assign w_rs = i_ir_hi[1:0];

  always_comb begin
    o_ctrl = ctrl_idle();
    // Reset overrides everything so no partial write lands mid-instruction
    if (!i_reset) begin
      case (i_state)
        ST_CLEAR: begin
          o_ctrl.rf_reg_sel  = 4'b0000;
          o_ctrl.arf_reg_sel = c_ARF_EN_ALL;
          o_ctrl.rf_fun_sel  = c_FUN_CLR;
          o_ctrl.arf_fun_sel = c_FUN_CLR;
        end

        ST_FETCH_H, ST_FETCH_L: begin
          o_ctrl.arf_outd_sel = c_ARF_PC;
          o_ctrl.mem_cs       = 1'b0;
          o_ctrl.mem_wr       = 1'b0;
          o_ctrl.ir_enable    = 1'b1;
          o_ctrl.ir_lh        = (i_state == ST_FETCH_L);
          o_ctrl.ir_funsel    = c_FUN_LOAD;
          o_ctrl.arf_reg_sel  = c_ARF_EN_PC;
          o_ctrl.arf_fun_sel  = c_FUN_INC;
        end

        ST_EXEC1: begin
          case (w_op)
            c_OP_LD, c_OP_ST: begin
              o_ctrl.mux_b_sel   = c_MUXB_IMM;
              o_ctrl.arf_fun_sel = c_FUN_LOAD;
              o_ctrl.arf_reg_sel = c_ARF_EN_AR;
            end
            c_OP_MOVI: begin
              o_ctrl.mux_a_sel  = c_MUXA_IMM;
              o_ctrl.rf_fun_sel = c_FUN_LOAD;
              o_ctrl.rf_reg_sel = rd_sel(w_rd);
            end
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR,
            c_OP_NOT, c_OP_LSL, c_OP_LSR: begin
              o_ctrl.rf_outa_sel = w_rd;
              o_ctrl.rf_outb_sel = w_rs;
              o_ctrl.alu_fun_sel = alu_code(w_op);
              o_ctrl.mux_c_sel   = 1'b1;
              o_ctrl.mux_a_sel   = c_MUXA_ALU;
              o_ctrl.rf_fun_sel  = c_FUN_LOAD;
              o_ctrl.rf_reg_sel  = rd_sel(w_rd);
            end
            c_OP_INC: begin
              o_ctrl.rf_fun_sel = c_FUN_INC;
              o_ctrl.rf_reg_sel = rd_sel(w_rd);
            end
            c_OP_DEC: begin
              o_ctrl.rf_fun_sel = c_FUN_DEC;
              o_ctrl.rf_reg_sel = rd_sel(w_rd);
            end
            c_OP_BRA: begin
              o_ctrl.mux_b_sel   = c_MUXB_IMM;
              o_ctrl.arf_fun_sel = c_FUN_LOAD;
              o_ctrl.arf_reg_sel = c_ARF_EN_PC;
            end
            c_OP_BZ: begin
              if (i_z) begin
                o_ctrl.mux_b_sel   = c_MUXB_IMM;
                o_ctrl.arf_fun_sel = c_FUN_LOAD;
                o_ctrl.arf_reg_sel = c_ARF_EN_PC;
              end
            end
            default: begin
            end
          endcase
        end

        ST_EXEC2: begin
          case (w_op)
            c_OP_LD: begin
              o_ctrl.arf_outd_sel = c_ARF_AR;
              o_ctrl.mem_cs       = 1'b0;
              o_ctrl.mux_a_sel    = c_MUXA_MEM;
              o_ctrl.rf_fun_sel   = c_FUN_LOAD;
              o_ctrl.rf_reg_sel   = rd_sel(w_rd);
            end
            c_OP_ST: begin
              o_ctrl.arf_outd_sel = c_ARF_AR;
              o_ctrl.rf_outa_sel  = w_rd;
              o_ctrl.mux_c_sel    = 1'b1;
              o_ctrl.alu_fun_sel  = c_ALU_PASS;
              o_ctrl.mem_cs       = 1'b0;
              o_ctrl.mem_wr       = 1'b1;
            end
            default: begin
            end
          endcase
        end

        ST_HALT: begin
          o_ctrl.halted = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Hardwired sequencer for the 8-bit ALUSystem: state register and
//            next-state logic; control lines come from cu_decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import cu_pkg::*;
#(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ALU_Flags,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_FETCH_H;

  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_unused;

  // Immediate bits are routed by the datapath muxes, not by this block
  assign w_unused = ^{IR_Out[7:0], ALU_Flags[3:1]};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_RESET_STATE;
    end else begin
      case (r_state)
        ST_CLEAR:   r_state <= ST_FETCH_H;
        ST_FETCH_H: r_state <= ST_FETCH_L;
        ST_FETCH_L: r_state <= ST_EXEC1;
        ST_EXEC1: begin
          case (IR_Out[15:12])
            c_OP_LD, c_OP_ST: r_state <= ST_EXEC2;
            c_OP_HLT:         r_state <= ST_HALT;
            default:          r_state <= ST_FETCH_H;
          endcase
        end
        ST_EXEC2:   r_state <= ST_FETCH_H;
        ST_HALT:    r_state <= ST_HALT;
        default:    r_state <= ST_FETCH_H;
      endcase
    end
  end

  cu_decode u_decode (
    .i_state (r_state),
    .i_reset (Reset),
    .i_ir_hi (IR_Out[15:8]),
    .i_z     (ALU_Flags[0]),
    .o_ctrl  (w_ctrl)
  );

  assign RF_OutASel  = w_ctrl.rf_outa_sel;
  assign RF_OutBSel  = w_ctrl.rf_outb_sel;
  assign RF_FunSel   = w_ctrl.rf_fun_sel;
  assign RF_RegSel   = w_ctrl.rf_reg_sel;
  assign ALU_FunSel  = w_ctrl.alu_fun_sel;
  assign ARF_OutCSel = w_ctrl.arf_outc_sel;
  assign ARF_OutDSel = w_ctrl.arf_outd_sel;
  assign ARF_FunSel  = w_ctrl.arf_fun_sel;
  assign ARF_RegSel  = w_ctrl.arf_reg_sel;
  assign IR_LH       = w_ctrl.ir_lh;
  assign IR_Enable   = w_ctrl.ir_enable;
  assign IR_Funsel   = w_ctrl.ir_funsel;
  assign Mem_WR      = w_ctrl.mem_wr;
  assign Mem_CS      = w_ctrl.mem_cs;
  assign MuxASel     = w_ctrl.mux_a_sel;
  assign MuxBSel     = w_ctrl.mux_b_sel;
  assign MuxCSel     = w_ctrl.mux_c_sel;
  assign Halted      = w_ctrl.halted;
  assign State       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit: directed scenarios plus a
//            randomized instruction stream against a per-phase reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  localparam logic [2:0] c_S_CLEAR = 3'd0;
  localparam logic [2:0] c_S_FH    = 3'd1;
  localparam logic [2:0] c_S_FL    = 3'd2;
  localparam logic [2:0] c_S_E1    = 3'd3;
  localparam logic [2:0] c_S_E2    = 3'd4;
  localparam logic [2:0] c_S_HALT  = 3'd5;

  // ALU function code for each opcode that routes through the ALU
  localparam logic [3:0] c_ALU_TAB [0:15] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9,
                                              4'h2, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  typedef struct packed {
    logic [1:0] rf_a;
    logic [1:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic [2:0] state;
  } word_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IR_Out = 16'h0000;
  logic [3:0]  ALU_Flags = 4'h0;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [2:0]  ARF_RegSel, State;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;
  logic [1:0]  IR_Funsel, MuxASel, MuxBSel;

  int compared   = 0;
  int mismatched = 0;

  word_t obs;
  assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted, State};

  control_unit #(.CLEAR_ON_RESET(1)) u_dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_Flags(ALU_Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Halted(Halted), .State(State)
  );

  always #5 Clock = ~Clock;

  // Drive one cycle's inputs just after the edge, then wait to the sampling point
  task automatic tick(input logic [15:0] ir, input logic [3:0] fl, input logic rs);
    @(posedge Clock);
    #1;
    IR_Out    = ir;
    ALU_Flags = fl;
    Reset     = rs;
    @(negedge Clock);
  endtask

  function automatic word_t m_idle(input logic [2:0] st);
    word_t w;
    w         = '0;
    w.rf_reg  = 4'b1111;
    w.arf_reg = 3'b111;
    w.mem_cs  = 1'b1;
    w.state   = st;
    return w;
  endfunction

  function automatic word_t m_fetch(input logic lh);
    word_t w;
    w         = m_idle(lh ? c_S_FL : c_S_FH);
    w.mem_cs  = 1'b0;
    w.ir_en   = 1'b1;
    w.ir_lh   = lh;
    w.ir_fun  = 2'd2;
    w.arf_reg = 3'b110;
    w.arf_fun = 2'd1;
    return w;
  endfunction

  function automatic word_t m_exec1(input logic [15:0] ir, input logic z);
    word_t      w;
    int         op;
    logic [3:0] rd_en;
    w     = m_idle(c_S_E1);
    op    = int'(ir[15:12]);
    rd_en = 4'b1111;
    rd_en[ir[11:10]] = 1'b0;
    if (op <= 1) begin
      w.mux_b = 2'd1; w.arf_fun = 2'd2; w.arf_reg = 3'b101;
    end else if (op == 2) begin
      w.mux_a = 2'd0; w.rf_fun = 2'd2; w.rf_reg = rd_en;
    end else if (op >= 3 && op <= 10) begin
      w.rf_a = ir[11:10]; w.rf_b = ir[9:8]; w.mux_c = 1'b1; w.mux_a = 2'd3;
      w.rf_fun = 2'd2; w.rf_reg = rd_en; w.alu = c_ALU_TAB[op];
    end else if (op == 11 || op == 12) begin
      w.rf_reg = rd_en; w.rf_fun = (op == 11) ? 2'd1 : 2'd0;
    end else if (op == 13 || (op == 14 && z)) begin
      w.mux_b = 2'd1; w.arf_fun = 2'd2; w.arf_reg = 3'b110;
    end
    return w;
  endfunction

  function automatic word_t m_exec2(input logic [15:0] ir);
    word_t      w;
    logic [3:0] rd_en;
    w     = m_idle(c_S_E2);
    rd_en = 4'b1111;
    rd_en[ir[11:10]] = 1'b0;
    w.arf_d  = 2'd2;
    w.mem_cs = 1'b0;
    if (ir[15:12] == 4'h0) begin
      w.mux_a = 2'd1; w.rf_fun = 2'd2; w.rf_reg = rd_en;
    end else begin
      w.rf_a = ir[11:10]; w.mux_c = 1'b1; w.mem_wr = 1'b1;
    end
    return w;
  endfunction

  task automatic test_reset();
    word_t e;
    tick(16'h0000, 4'h0, 1'b1);
    e = m_idle(c_S_CLEAR);
    compared++;
    if (obs[37:3] !== e[37:3]) begin
      mismatched++; $display("FAIL reset_idle got %h want %h", obs[37:3], e[37:3]);
    end
    tick(16'h0000, 4'h0, 1'b1);
    tick(16'hB000, 4'h0, 1'b0);
    e = m_idle(c_S_CLEAR);
    e.rf_reg = 4'b0000; e.arf_reg = 3'b000; e.rf_fun = 2'd3; e.arf_fun = 2'd3;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_clear got %h want %h", obs, e); end
    tick(16'hB000, 4'h0, 1'b0);
    e = m_idle(c_S_FH);
    e.mem_cs = 1'b0; e.ir_en = 1'b1; e.ir_fun = 2'd2; e.arf_reg = 3'b110; e.arf_fun = 2'd1;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_fetch_h got %h want %h", obs, e); end
    tick(16'hB000, 4'h0, 1'b0);
    tick(16'hB000, 4'h0, 1'b0);
  endtask

  task automatic test_movi();
    word_t e;
    tick(16'h2A3C, 4'h0, 1'b0);
    tick(16'h2A3C, 4'h0, 1'b0);
    tick(16'h2A3C, 4'h0, 1'b0);
    e = m_idle(c_S_E1);
    e.mux_a = 2'd0; e.rf_fun = 2'd2; e.rf_reg = 4'b1011;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL movi_exec1 got %h want %h", obs, e); end
    tick(16'h3100, 4'h0, 1'b0);
    compared++;
    if (obs.state !== c_S_FH) begin
      mismatched++; $display("FAIL movi_return got %0d want %0d", obs.state, c_S_FH);
    end
  endtask

  task automatic test_add();
    word_t e;
    tick(16'h3100, 4'h0, 1'b0);
    tick(16'h3100, 4'h0, 1'b0);
    e = m_idle(c_S_E1);
    e.rf_a = 2'd0; e.rf_b = 2'd1; e.alu = 4'b0100; e.mux_c = 1'b1; e.mux_a = 2'd3;
    e.rf_fun = 2'd2; e.rf_reg = 4'b1110;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL add_exec1 got %h want %h", obs, e); end
  endtask

  task automatic test_st();
    word_t e;
    tick(16'h1440, 4'h0, 1'b0);
    tick(16'h1440, 4'h0, 1'b0);
    tick(16'h1440, 4'h0, 1'b0);
    e = m_idle(c_S_E1);
    e.mux_b = 2'd1; e.arf_fun = 2'd2; e.arf_reg = 3'b101;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL st_exec1 got %h want %h", obs, e); end
    tick(16'h1440, 4'h0, 1'b0);
    e = m_idle(c_S_E2);
    e.arf_d = 2'd2; e.rf_a = 2'd1; e.mux_c = 1'b1; e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL st_exec2 got %h want %h", obs, e); end
    tick(16'hE010, 4'h0, 1'b0);
    compared++;
    if (obs.state !== c_S_FH) begin
      mismatched++; $display("FAIL st_4cycle got %0d want %0d", obs.state, c_S_FH);
    end
  endtask

  task automatic test_bz();
    word_t e;
    tick(16'hE010, 4'h0, 1'b0);
    tick(16'hE010, 4'hE, 1'b0);
    e = m_idle(c_S_E1);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL bz_not_taken got %h want %h", obs, e); end
    for (int k = 0; k < 3; k++) tick(16'hE010, 4'h1, 1'b0);
    e = m_idle(c_S_E1);
    e.mux_b = 2'd1; e.arf_fun = 2'd2; e.arf_reg = 3'b110;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL bz_taken got %h want %h", obs, e); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ir;
      int          len;
      word_t       e;
      ir = 16'($urandom);
      if (ir[15:12] == 4'hF) ir[15:12] = 4'($urandom_range(0, 14));
      len = (ir[15:12] <= 4'h1) ? 4 : 3;
      for (int ph = 0; ph < len; ph++) begin
        tick(ir, 4'($urandom), 1'b0);
        case (ph)
          0:       e = m_fetch(1'b0);
          1:       e = m_fetch(1'b1);
          2:       e = m_exec1(ir, ALU_Flags[0]);
          default: e = m_exec2(ir);
        endcase
        compared++;
        if (obs !== e) begin
          mismatched++;
          $display("FAIL random n=%0d ir=%h ph=%0d got %h want %h", n, ir, ph, obs, e);
        end
      end
    end
  endtask

  task automatic test_halt();
    word_t e;
    tick(16'hF000, 4'h0, 1'b0);
    tick(16'hF000, 4'h0, 1'b0);
    tick(16'hF000, 4'h0, 1'b0);
    e = m_idle(c_S_E1);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL hlt_exec1 got %h want %h", obs, e); end
    for (int k = 0; k < 20; k++) begin
      tick(16'($urandom), 4'($urandom), 1'b0);
      e = m_idle(c_S_HALT);
      e.halted = 1'b1;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL halt_hold k=%0d got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    word_t e;
    tick(16'hF000, 4'h0, 1'b1);
    e = m_idle(c_S_HALT);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_in_halt got %h want %h", obs, e); end
    tick(16'h0880, 4'h0, 1'b0);
    compared++;
    if (obs.state !== c_S_CLEAR) begin
      mismatched++; $display("FAIL halt_exit got %0d want %0d", obs.state, c_S_CLEAR);
    end
    for (int k = 0; k < 3; k++) tick(16'h0880, 4'h0, 1'b0);
    tick(16'h0880, 4'h0, 1'b1);
    e = m_idle(c_S_E2);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_in_exec2 got %h want %h", obs, e); end
    tick(16'h0880, 4'h0, 1'b0);
    e = m_idle(c_S_CLEAR);
    e.rf_reg = 4'b0000; e.arf_reg = 3'b000; e.rf_fun = 2'd3; e.arf_fun = 2'd3;
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_mid_clear got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add();
    test_st();
    test_bz();
    test_random();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
